// File: rtl/alsu_req_sequencer.sv
// alsu_req_sequencer: shares one registered ALSU between two requesters with round-robin/lock arbitration.
//
// Optional feature macro: ALSU_SEQ_ERR_CNT_EN adds the err_count output.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   reqN_valid/cmd/lock       requester N command, lock keeps the grant after this command
//   reqN_ready                command from requester N accepted on this edge
//   alsu_cmd                  registered command word driven to the ALSU
//   alsu_out                  ALSU registered result
//   rsp_valid/id/data/err     one-cycle in-order response strobe, requester index, result, rejection flag
//   busy                      any command in flight
//   err_count                 saturating count of rejected commands (ALSU_SEQ_ERR_CNT_EN only)
module alsu_req_sequencer #(
    parameter int          ALSU_LAT = 2,
    parameter logic [15:0] IDLE_CMD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_cmd,
    input  logic        req0_lock,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_cmd,
    input  logic        req1_lock,
    output logic        req1_ready,
    output logic [15:0] alsu_cmd,
    input  logic [5:0]  alsu_out,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [5:0]  rsp_data,
    output logic        rsp_err,
    output logic        busy
`ifdef ALSU_SEQ_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);
    // bit 0 = preferred/owning requester, bit 1 = locked
    typedef enum logic [1:0] {RR0 = 2'b00, RR1 = 2'b01, LOCK0 = 2'b10, LOCK1 = 2'b11} state_t;
    state_t            state, state_nxt;
    logic              acc, lk, inv;
    logic [15:0]       cmd;
    logic [2:0]        op;
    logic [ALSU_LAT:0] pv, pid, perr;

    always_comb begin
        req0_ready = ~rst & req0_valid & (~state[0] | (~state[1] & ~req1_valid));
        req1_ready = ~rst & req1_valid & (state[0] | (~state[1] & ~req0_valid));
        acc        = req0_ready | req1_ready;
        cmd        = req1_ready ? req1_cmd : req0_cmd;
        lk         = req1_ready ? req1_lock : req0_lock;
        op         = cmd[15:13];
        // opcodes 110/111, or a reduction request on anything but AND/XOR
        inv        = (op[2] & op[1]) | ((cmd[4] | cmd[3]) & (op[2] | op[1]));
        state_nxt  = !acc ? state :
                     lk   ? (req1_ready ? LOCK1 : LOCK0) :
                            (req1_ready ? RR0 : RR1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RR0;
            alsu_cmd  <= IDLE_CMD;
            pv        <= '0;
            pid       <= '0;
            perr      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            alsu_cmd  <= (acc & ~inv) ? cmd : IDLE_CMD;
            pv        <= {pv[ALSU_LAT-1:0], acc};
            pid       <= {pid[ALSU_LAT-1:0], req1_ready};
            perr      <= {perr[ALSU_LAT-1:0], acc & inv};
            rsp_valid <= pv[ALSU_LAT];
            rsp_id    <= pid[ALSU_LAT];
            rsp_err   <= perr[ALSU_LAT];
            rsp_data  <= (pv[ALSU_LAT] & ~perr[ALSU_LAT]) ? alsu_out : '0;
        end
    end

    assign busy = |pv;

`ifdef ALSU_SEQ_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (acc & inv & ~&err_count)
            err_count <= err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_alsu_req_sequencer.sv
// tb_alsu_req_sequencer: scoreboard bench for alsu_req_sequencer with a behavioural two-stage ALSU.
module tb_alsu_req_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_lock = 1'b0, req1_valid = 1'b0, req1_lock = 1'b0;
    logic [15:0] req0_cmd = '0, req1_cmd = '0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
    logic [15:0] alsu_cmd;
    logic [5:0]  alsu_out, rsp_data;
`ifdef ALSU_SEQ_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    alsu_req_sequencer dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_lock(req0_lock), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_lock(req1_lock), .req1_ready(req1_ready),
        .alsu_cmd(alsu_cmd), .alsu_out(alsu_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
`ifdef ALSU_SEQ_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    // ALSU stand-in: input register then output register
    logic [15:0] in_reg;
    function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] o);
        logic [5:0] a, b;
        a = {3'b0, c[12:10]};
        b = {3'b0, c[9:7]};
        case (c[15:13])
            3'd0:    return a & b;
            3'd1:    return a ^ b;
            3'd2:    return a + b + {5'b0, c[6]};
            3'd3:    return a * b;
            3'd4:    return c[0] ? {o[4:0], c[5]} : {c[5], o[5:1]};
            3'd5:    return c[0] ? {o[4:0], o[5]} : {o[0], o[5:1]};
            default: return 6'd0;
        endcase
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            in_reg   <= '0;
            alsu_out <= '0;
        end else begin
            in_reg   <= alsu_cmd;
            alsu_out <= alsu_f(in_reg, alsu_out);
        end
    end

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       id;
        logic [5:0] data;
        logic       err;
        int         due;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_cycle", cnt, e.due);
            end
        end
    end

    logic [15:0] prev_cmd = 16'h0000;

    task automatic drive(input logic a0, input logic [15:0] c0, input logic l0,
                         input logic a1, input logic [15:0] c1, input logic l1,
                         input logic r0, input logic r1, input logic [15:0] ecmd,
                         input logic eid, input logic [5:0] edat, input logic eerr);
        exp_t e;
        @(negedge clk);
        chk("alsu_cmd", alsu_cmd, prev_cmd);
        rst = 1'b0;
        req0_valid = a0; req0_cmd = c0; req0_lock = l0;
        req1_valid = a1; req1_cmd = c1; req1_lock = l1;
        #1;
        chk("req0_ready", req0_ready, r0);
        chk("req1_ready", req1_ready, r1);
        if (r0 | r1) begin
            e.id = eid; e.data = edat; e.err = eerr; e.due = cnt + 4;
            q.push_back(e);
        end
        prev_cmd = ecmd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 6'd0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req0_cmd = 16'h55C0; req1_valid = 1'b1; req1_cmd = 16'h7F00;
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        @(negedge clk);
        chk("rst_alsu_cmd", alsu_cmd, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
`ifdef ALSU_SEQ_ERR_CNT_EN
        chk("rst_err_count", err_count, 0);
`endif
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        prev_cmd = 16'h0000;
    endtask

    initial begin
        do_reset();
        // single add
        drive(1, 16'h55C0, 0, 0, 16'h0, 0, 1, 0, 16'h55C0, 0, 6'd9, 0);
        idle(5);
        // round robin from reset
        do_reset();
        drive(1, 16'h7F00, 0, 1, 16'h55C0, 0, 1, 0, 16'h7F00, 0, 6'd42, 0);
        drive(1, 16'h7F00, 0, 1, 16'h55C0, 0, 0, 1, 16'h55C0, 1, 6'd9, 0);
        drive(1, 16'h7F00, 0, 1, 16'h55C0, 0, 1, 0, 16'h7F00, 0, 6'd42, 0);
        drive(1, 16'h7F00, 0, 1, 16'h55C0, 0, 0, 1, 16'h55C0, 1, 6'd9, 0);
        idle(5);
        // invalid commands: opcode 110, reduction on add, opcode 111 with bypass
        drive(0, 16'h0, 0, 1, 16'hC000, 0, 0, 1, 16'h0000, 1, 6'd0, 1);
        idle(2);
`ifdef ALSU_SEQ_ERR_CNT_EN
        chk("err_count_1", err_count, 1);
`endif
        drive(1, 16'h4010, 0, 0, 16'h0, 0, 1, 0, 16'h0000, 0, 6'd0, 1);
        drive(0, 16'h0, 0, 1, 16'hE006, 0, 0, 1, 16'h0000, 1, 6'd0, 1);
        idle(5);
`ifdef ALSU_SEQ_ERR_CNT_EN
        chk("err_count_3", err_count, 3);
`endif
        // lock chain: mult then shift, req1 held off
        do_reset();
        drive(1, 16'h7F00, 1, 1, 16'h55C0, 0, 1, 0, 16'h7F00, 0, 6'd42, 0);
        drive(1, 16'h8021, 0, 1, 16'h55C0, 0, 1, 0, 16'h8021, 0, 6'h15, 0);
        drive(1, 16'h7F00, 0, 1, 16'h55C0, 1, 0, 1, 16'h55C0, 1, 6'd9, 0);
        // locked requester idle: nothing accepted, shift then sees operand 0
        drive(1, 16'h7F00, 0, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 6'd0, 0);
        drive(1, 16'h7F00, 0, 1, 16'h8021, 0, 0, 1, 16'h8021, 1, 6'd1, 0);
        drive(1, 16'h7F00, 0, 0, 16'h0, 0, 1, 0, 16'h7F00, 0, 6'd42, 0);
        idle(5);
        // reset while a command is in flight
        @(negedge clk);
        chk("alsu_cmd", alsu_cmd, prev_cmd);
        req0_valid = 1'b1; req0_cmd = 16'h55C0; req0_lock = 1'b0; req1_valid = 1'b0;
        #1;
        chk("mid_req0_ready", req0_ready, 1);
        @(negedge clk);
        chk("mid_alsu_cmd", alsu_cmd, 16'h55C0);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        req1_valid = 1'b1; req1_cmd = 16'h55C0;
        #1;
        chk("mid_rst_req0_ready", req0_ready, 0);
        chk("mid_rst_req1_ready", req1_ready, 0);
        @(negedge clk);
        chk("mid_post_alsu_cmd", alsu_cmd, 16'h0000);
        chk("mid_post_busy", busy, 0);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        prev_cmd = 16'h0000;
        idle(6);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) chk("rsp_timeout_pending", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alsu_req_sequencer.md
Name: alsu_req_sequencer

Overview:
- Shares one registered ALSU between two requesters.
- Round-robin arbitration, with an optional lock so one requester can issue an uninterrupted shift/rotate chain.
- Pre-screens commands the ALSU treats as invalid, so the ALSU never enters its blink/error state.
- Drives the ALSU control/data inputs from a registered command word, samples the ALSU result after a fixed latency, and returns in-order tagged responses.

Parameters:
- ALSU_LAT, 2: clock edges from alsu_cmd changing to alsu_out reflecting it (ALSU input register plus output register).
- IDLE_CMD, 16'h0000: command driven whenever nothing is issued (AND of A=0, B=0; ALSU output becomes 0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a command.
- req0_cmd  in  16  requester 0 command word.
- req0_lock  in  1  keep the grant after this command.
- req0_ready  out  1  command accepted this edge (valid & ready).
- req1_valid, req1_cmd, req1_lock, req1_ready: same as requester 0, for requester 1.
- alsu_cmd  out  16  registered command to the ALSU.
- alsu_out  in  6  ALSU registered result.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  1  requester index of the response.
- rsp_data  out  6  result; 0 when rsp_err=1.
- rsp_err  out  1  command rejected as invalid.
- busy  out  1  any command in flight.

Behaviour:
- Command word packing: [15:13] opcode, [12:10] A, [9:7] B, [6] cin, [5] serial_in, [4] red_op_A, [3] red_op_B, [2] bypass_A, [1] bypass_B, [0] direction.
- Reset (sync, active-high):
  - alsu_cmd=IDLE_CMD; rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0; busy=0.
  - Pipeline cleared; arbiter state=RR0 (requester 0 preferred); both ready=0 during the rst cycle.
  - Reset mid-operation discards all in-flight commands; no response is produced for them.
- Arbiter states: RR0, RR1, LOCK0, LOCK1.
  - RRx: if both requesters are valid, requester x is granted; otherwise the single valid requester is granted.
  - After an accept from requester n with lock=0: next state is RR(1-n).
  - After an accept from requester n with lock=1: next state is LOCKn.
  - LOCKn: only reqn_ready may assert. The state exits to RR(1-n) on an accept with lock=0.
  - In LOCKn with reqn_valid=0: IDLE_CMD is issued that cycle. This breaks a shift chain; the requester is responsible for avoiding gaps.
- Ready: combinational from arbiter state and the valid inputs. At most one ready high per cycle. One accept per cycle maximum, so throughput is 1 command per cycle.
- Invalid check (on the accepted command):
  - Invalid if opcode is 110 or 111.
  - Invalid if (red_op_A or red_op_B) and opcode is not 000 and not 001.
  - Invalid regardless of bypass flags.
  - An invalid command drives IDLE_CMD on alsu_cmd and is marked err in the pipeline.
- Issue: on the accept edge, alsu_cmd <= the accepted cmd (or IDLE_CMD if invalid). On any edge without an accept, alsu_cmd <= IDLE_CMD. Each command is held for exactly one cycle.
- Pipeline: a shift register of {valid, id, err}, ALSU_LAT+1 stages.
  - alsu_out is registered into rsp_data exactly ALSU_LAT+1 edges after the accept edge, i.e. rsp_valid is high in the cycle following edge ALSU_LAT+1.
  - Default response latency is 3 edges after accept.
  - Responses are strictly in acceptance order; back-to-back accepts give back-to-back responses.
  - There is no response backpressure.
- Shift/rotate (opcodes 100/101) operate on the ALSU result of the command issued in the immediately preceding cycle. If that cycle issued IDLE_CMD, the operand is 0.
- busy = any pipeline valid bit set.

Optional Feature:
- Macro: ALSU_SEQ_ERR_CNT_EN.
- Defined:
  - Adds output err_count [7:0], reset to 0.
  - Increments when an invalid command is accepted; saturates at 8'hFF.
  - Simultaneous rst wins.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Add: req0 cmd=16'h55C0 (add, A=5, B=3, cin=1), req1 idle → req0_ready=1 at the accept edge; alsu_cmd=16'h55C0 for one cycle; 3 edges later rsp_valid=1, rsp_id=0, rsp_data=6'd9, rsp_err=0.
- Round robin: both valid every cycle, req0 cmd=16'h7F00 (mult 7×6), req1 cmd=16'h55C0, lock=0, out of reset → accept order 0,1,0,1; rsp_data sequence 42, 9, 42, 9 on consecutive cycles with rsp_id alternating.
- Invalid: req1 cmd=16'hC000 (opcode 110) → alsu_cmd stays 16'h0000; rsp_err=1, rsp_data=0, rsp_id=1, 3 edges later. With the macro defined, err_count increments 0→1.
- Lock chain: req0 cmd=16'h7F00 with lock=1, next cycle req0 cmd=16'h8021 (shift left, serial_in=1) with lock=0, req1 valid throughout → req1_ready=0 during the lock; responses 42 then 6'h15; req1 is granted on the following cycle.
- Reset mid-flight: accept a command, assert rst on the next edge → no rsp_valid afterwards; busy=0, alsu_cmd=16'h0000, both ready=0 during rst.
